// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial LSB-first adder with start/busy/done handshake
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, s_sh;
  logic [CW-1:0] cnt;
  logic c, hs, hc, s, cn, last, accept;
  assign hs = a_sh[0] ^ b_sh[0];
  assign hc = a_sh[0] & b_sh[0];
  assign s = hs ^ c;
  assign cn = hc | (hs & c);
  assign last = cnt == CW'(WIDTH - 1);
  assign accept = start && state != ADD;
  assign busy = state == ADD;
  assign done = state == DONE;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    state_nx = accept ? ADD : state == ADD ? (last ? DONE : ADD) : IDLE;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      s_sh <= '0;
      c <= 1'b0;
      cnt <= '0;
      sum <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a_sh <= a;
      b_sh <= b;
      s_sh <= '0;
      c <= 1'b0;
      cnt <= '0;
    end else if (state == ADD) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      s_sh <= {s, s_sh[WIDTH-1:1]};
      c <= cn;
      cnt <= cnt + 1'b1;
      if (last) begin
        sum <= {s, s_sh[WIDTH-1:1]};
        carry_out <= cn;
      end
    end
endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: scoreboard bench for serial_adder_seq at WIDTH=8
module tb_serial_adder_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] a = '0, b = '0, sum;
  logic busy, done, carry_out;
  logic [8:0] q[$];
  logic [8:0] prev, exp_v;
  int total = 0, pass = 0;

  serial_adder_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got result %0h expected no done", {carry_out, sum});
      end else begin
        exp_v = q.pop_front();
        chk("result", {23'd0, carry_out, sum}, {23'd0, exp_v});
      end
    end
    if (busy === 1'b1) chk("sum_stable", {23'd0, carry_out, sum}, {23'd0, prev});
    prev = {carry_out, sum};
  end

  task automatic op(input logic [7:0] x, input logic [7:0] y);
    int n = 0;
    @(negedge clk);
    start = 1'b1; a = x; b = y;
    q.push_back(9'(x) + 9'(y));
    @(negedge clk);
    start = 1'b0; a = ~x; b = ~y;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom);
    end
    chk("busy_cycles", n, 8);
    chk("done_pulse", {31'd0, done}, 1);
  endtask

  task automatic wait_done(input string nm, input int exp_n);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
    chk(nm, n, exp_n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_state", {28'd0, busy, done, carry_out, sum[0]}, 0);
    chk("reset_sum", {24'd0, sum}, 0);
    rst_n = 1'b1;
    op(8'h3C, 8'h0F);
    op(8'hFF, 8'h01);
    op(8'hFF, 8'hFF);
    op(8'h00, 8'h00);
    op(8'h80, 8'h7F);
    // start re-pulsed while adding must be ignored
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01;
    q.push_back(9'h002);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'hAA; b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    wait_done("t3_done_time", 5);
    @(negedge clk);
    chk("t3_no_reaccept", {30'd0, busy, done}, 0);
    // reset mid-add discards the partial result
    @(negedge clk);
    start = 1'b1; a = 8'h80; b = 8'h80;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_abort", {21'd0, busy, done, carry_out, sum}, 0);
    rst_n = 1'b1;
    op(8'h12, 8'h34);
    // start held high through DONE gives back-to-back adds
    @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h02;
    q.push_back(9'h003);
    wait_done("t5_first_done", 9);
    a = 8'h10; b = 8'h20;
    q.push_back(9'h030);
    @(negedge clk);
    start = 1'b0;
    chk("t5_reaccept", {30'd0, busy, done}, 2);
    wait_done("t5_second_done", 8);
    for (int i = 0; i < 60; i++) op(8'($urandom), 8'($urandom));
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
